gait_sequencer: RTL and testbench
=================================

// Module: gait_sequencer
// PURPOSE
//  Sequences the hexapod leg ROM servo controllers. Owns homing time, the shared
//  ROM position index and servo enable, and gait-bank selection.
//  Replaces the free-running position counter and separate homing timer at top level.
//  Sits between the heartrate tick and all twelve rom_servo_crtl instances.
//  Gait changes are applied only at gait-cycle boundaries so legs never jump mid-step.
// PARAMETERS
//  ROM_SIZE    64   steps per gait cycle; position range 0..ROM_SIZE-1 (2..256)
//  HOME_TICKS  350  ticks spent homing before walking (7 s at 50 Hz)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  tick        in   1  one-clk step strobe from heartrate_hz
//  start       in   1  run request level (SW2)
//  cmd         in   2  00 stop, 01 forward, 10 backward, 11 turn
//  position    out  8  ROM index to all rom_servo_crtl .position
//  enable      out  1  servo enable; 0 = servos hold HOME
//  gait_sel    out  2  active gait bank (latched cmd)
//  state       out  2  00 IDLE, 01 HOMING, 10 WALK, 11 DRAIN (debug LEDs)
//  cycle_done  out  1  1-clk pulse when position wraps into 0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; position=0; enable=0; gait_sel=00;
//    cycle_done=0; home counter=0.
//  All outputs are registered; update in the clk after the causing input or tick.
//  IDLE: enable=0, position=0, tick ignored; start=1 -> HOMING with home counter cleared.
//  HOMING: enable=0; home counter +1 per tick.
//    - On the tick where counter==HOME_TICKS-1: -> WALK; enable=1; position=0;
//      gait_sel<=cmd.
//    - start=0 -> IDLE immediately, counter cleared.
//  WALK: enable=1; on each tick step position by gait_sel:
//    - 01/11: +1, ROM_SIZE-1 wraps to 0.
//    - 10: -1, 0 wraps to ROM_SIZE-1.
//    - 00: hold at 0 (standing).
//  Boundary = tick that moves position into 0 (fwd from ROM_SIZE-1, back from 1).
//    - That step uses the old direction.
//    - cycle_done pulses in the same clk the new position appears.
//    - gait_sel<=cmd in that same clk; the next tick uses the new gait.
//  gait_sel=00: every tick is a boundary; cmd applies on the next tick, no pulse.
//  cmd changes mid-cycle are not queued; cmd is sampled only at the boundary.
//  start=0 in WALK -> DRAIN.
//  DRAIN: enable=1; keep stepping with the current gait, no gait change.
//    - At boundary -> IDLE: enable=0, position=0.
//    - If position==0 on DRAIN entry and gait_sel=00 -> IDLE next clk.
//    - start=1 during DRAIN: return to WALK; position continues, no re-homing.
//  tick coincident with a state transition is consumed by the transition only.
//  Arithmetic is 8-bit unsigned; ROM_SIZE-1 is compared as an 8-bit value.
// TESTING
//  1 Reset, start=1, cmd=01, 350 ticks: enable=0, state=01; after tick 350:
//    enable=1, position=0, state=10.
//  2 WALK fwd ROM_SIZE=64: 63 ticks -> position=63; next tick -> position=0,
//    cycle_done=1 for 1 clk.
//  3 cmd 01->10 at position=20: position climbs to 63, wraps to 0, then tick -> 63,
//    gait_sel=10.
//  4 Backward at position=1, tick -> 0 with cycle_done; at 0, tick -> 63 with no pulse.
//  5 start=0 at position=40 fwd: state=11, steps to 0 after 24 ticks, then state=00,
//    enable=0.
//  6 rst pulse mid-WALK at position=30: next clk state=00, position=0, enable=0;
//    start=0 mid-HOMING -> IDLE.

Source files
------------

// File: rtl/gait_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gait_sequencer
// Purpose  : Homing timer, shared ROM position index, servo enable and
//            gait-bank selection for the hexapod leg servo controllers.
//            Gait changes take effect only at gait-cycle boundaries.
// Revision : 1.0  initial release
// ============================================================================
module gait_sequencer #(
  parameter int ROM_SIZE   = 64,
  parameter int HOME_TICKS = 350
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [1:0] cmd,
  output logic [7:0] position,
  output logic       enable,
  output logic [1:0] gait_sel,
  output logic [1:0] state,
  output logic       cycle_done
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_HOMING = 2'b01;
  localparam logic [1:0] S_WALK   = 2'b10;
  localparam logic [1:0] S_DRAIN  = 2'b11;

  localparam logic [1:0] GAIT_STAND = 2'b00;
  localparam logic [1:0] GAIT_BACK  = 2'b10;

  localparam int          CNT_W     = (HOME_TICKS > 1) ? $clog2(HOME_TICKS) : 1;
  localparam logic [CNT_W-1:0] HOME_LAST = CNT_W'(HOME_TICKS - 1);
  localparam logic [7:0]  POS_LAST  = 8'(ROM_SIZE - 1);

  logic [CNT_W-1:0] home_cnt;
  logic [CNT_W-1:0] home_cnt_nxt;
  logic [1:0]       state_nxt;
  logic [7:0]       position_nxt;
  logic             enable_nxt;
  logic [1:0]       gait_sel_nxt;
  logic             cycle_done_nxt;
  logic [7:0]       step_pos;
  logic             boundary;
  logic             home_done;

  // Position one step ahead under the current gait; landing on 0 is a boundary
  always_comb begin
    step_pos = 8'd0;
    case (gait_sel)
      GAIT_STAND: step_pos = 8'd0;
      GAIT_BACK:  step_pos = (position == 8'd0) ? POS_LAST : position - 8'd1;
      default:    step_pos = (position == POS_LAST) ? 8'd0 : position + 8'd1;
    endcase
  end

  assign boundary  = (step_pos == 8'd0);
  assign home_done = tick && (home_cnt == HOME_LAST);

  // State and registered outputs; async reset returns everything to IDLE/home
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      position   <= 8'd0;
      enable     <= 1'b0;
      gait_sel   <= 2'b00;
      cycle_done <= 1'b0;
      home_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      position   <= position_nxt;
      enable     <= enable_nxt;
      gait_sel   <= gait_sel_nxt;
      cycle_done <= cycle_done_nxt;
      home_cnt   <= home_cnt_nxt;
    end
  end

  // Next-state selection; a start change wins over a coincident tick
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_HOMING;
      S_HOMING: begin
        if (!start)         state_nxt = S_IDLE;
        else if (home_done) state_nxt = S_WALK;
      end
      S_WALK:   if (!start) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (start)                        state_nxt = S_WALK;
        else if (gait_sel == GAIT_STAND)  state_nxt = S_IDLE;
        else if (tick && boundary)        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the homing counter
  always_comb begin
    position_nxt   = position;
    enable_nxt     = enable;
    gait_sel_nxt   = gait_sel;
    cycle_done_nxt = 1'b0;
    home_cnt_nxt   = home_cnt;
    case (state)
      S_IDLE: begin
        position_nxt = 8'd0;
        enable_nxt   = 1'b0;
        home_cnt_nxt = '0;
      end
      S_HOMING: begin
        enable_nxt = 1'b0;
        if (!start) begin
          home_cnt_nxt = '0;
        end else if (home_done) begin
          enable_nxt   = 1'b1;
          position_nxt = 8'd0;
          gait_sel_nxt = cmd;
          home_cnt_nxt = '0;
        end else if (tick) begin
          home_cnt_nxt = home_cnt + CNT_W'(1);
        end
      end
      S_WALK: begin
        enable_nxt = 1'b1;
        if (start && tick) begin
          position_nxt = step_pos;
          if (boundary) begin
            // Standing is a boundary on every tick but is not a cycle wrap
            cycle_done_nxt = (gait_sel != GAIT_STAND);
            gait_sel_nxt   = cmd;
          end
        end
      end
      S_DRAIN: begin
        enable_nxt = 1'b1;
        if (!start) begin
          if (gait_sel == GAIT_STAND) begin
            enable_nxt   = 1'b0;
            position_nxt = 8'd0;
          end else if (tick) begin
            position_nxt = step_pos;
            if (boundary) begin
              cycle_done_nxt = 1'b1;
              enable_nxt     = 1'b0;
            end
          end
        end
      end
      default: begin
        position_nxt = 8'd0;
        enable_nxt   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gait_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gait_sequencer
// Purpose  : Self-checking bench for gait_sequencer: directed scenarios
//            followed by randomized stimulus against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gait_sequencer;

  localparam int ROM_SIZE   = 64;
  localparam int HOME_TICKS = 350;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] position;
  logic       enable;
  logic [1:0] gait_sel;
  logic [1:0] state;
  logic       cycle_done;

  gait_sequencer #(
    .ROM_SIZE   (ROM_SIZE),
    .HOME_TICKS (HOME_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .cmd        (cmd),
    .position   (position),
    .enable     (enable),
    .gait_sel   (gait_sel),
    .state      (state),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 homing, 2 walk, 3 drain
  int m_mode, m_pos, m_en, m_gait, m_done, m_ticks;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int advance(input int p, input int g);
    if (g == 0) return 0;
    if (g == 2) return (p + ROM_SIZE - 1) % ROM_SIZE;
    return (p + 1) % ROM_SIZE;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_en = 0; m_gait = 0; m_done = 0; m_ticks = 0;
  endtask

  task automatic model_step(input int t, input int s, input int c);
    int np;
    m_done = 0;
    case (m_mode)
      0: begin
        m_pos = 0; m_en = 0;
        if (s != 0) begin m_mode = 1; m_ticks = 0; end
      end
      1: begin
        if (s == 0) begin
          m_mode = 0; m_ticks = 0;
        end else if (t != 0) begin
          m_ticks++;
          if (m_ticks == HOME_TICKS) begin
            m_mode = 2; m_en = 1; m_pos = 0; m_gait = c; m_ticks = 0;
          end
        end
      end
      2: begin
        if (s == 0) begin
          m_mode = 3;
        end else if (t != 0) begin
          np = advance(m_pos, m_gait);
          m_pos = np;
          if (np == 0) begin
            if (m_gait != 0) m_done = 1;
            m_gait = c;
          end
        end
      end
      default: begin
        if (s != 0) begin
          m_mode = 2;
        end else if (m_gait == 0) begin
          m_mode = 0; m_en = 0; m_pos = 0;
        end else if (t != 0) begin
          np = advance(m_pos, m_gait);
          m_pos = np;
          if (np == 0) begin
            m_done = 1; m_mode = 0; m_en = 0;
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("state", int'(state), m_mode);
    check("position", int'(position), m_pos);
    check("enable", int'(enable), m_en);
    check("gait_sel", int'(gait_sel), m_gait);
    check("cycle_done", int'(cycle_done), m_done);
  endtask

  // One clock: drive inputs, let the edge pass, advance model, compare
  task automatic cycle(input logic t, input logic s, input logic [1:0] c, input logic r);
    tick = t; start = s; cmd = c; rst = r;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_step(int'(t), int'(s), int'(c));
    compare_all();
  endtask

  logic       rs, rr, rt;
  logic [1:0] rc;

  initial begin
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_position", int'(position), 0);
    check("reset_enable", int'(enable), 0);
    check("reset_gait", int'(gait_sel), 0);
    check("reset_done", int'(cycle_done), 0);

    // Homing: 350 ticks then walk forward
    cycle(1'b0, 1'b1, 2'b01, 1'b0);
    check("homing_entry", int'(state), 1);
    repeat (HOME_TICKS - 1) cycle(1'b1, 1'b1, 2'b01, 1'b0);
    check("homing_hold_state", int'(state), 1);
    check("homing_hold_enable", int'(enable), 0);
    cycle(1'b1, 1'b1, 2'b01, 1'b0);
    check("walk_state", int'(state), 2);
    check("walk_enable", int'(enable), 1);
    check("walk_pos0", int'(position), 0);

    // Forward to 20, then request backward mid-cycle
    repeat (20) cycle(1'b1, 1'b1, 2'b01, 1'b0);
    check("fwd_pos20", int'(position), 20);
    repeat (43) cycle(1'b1, 1'b1, 2'b10, 1'b0);
    check("fwd_pos63", int'(position), 63);
    check("gait_not_yet", int'(gait_sel), 1);
    cycle(1'b1, 1'b1, 2'b10, 1'b0);
    check("wrap_pos", int'(position), 0);
    check("wrap_done", int'(cycle_done), 1);
    check("wrap_gait", int'(gait_sel), 2);
    cycle(1'b0, 1'b1, 2'b10, 1'b0);
    check("done_one_clk", int'(cycle_done), 0);
    cycle(1'b1, 1'b1, 2'b10, 1'b0);
    check("back_wrap_pos", int'(position), 63);
    check("back_wrap_nopulse", int'(cycle_done), 0);

    // Backward down to 0 (boundary), switch back to forward
    repeat (62) cycle(1'b1, 1'b1, 2'b01, 1'b0);
    check("back_pos1", int'(position), 1);
    cycle(1'b1, 1'b1, 2'b01, 1'b0);
    check("back_bound_done", int'(cycle_done), 1);
    check("back_bound_gait", int'(gait_sel), 1);

    // Drain from position 40
    repeat (40) cycle(1'b1, 1'b1, 2'b01, 1'b0);
    cycle(1'b1, 1'b0, 2'b01, 1'b0);
    check("drain_state", int'(state), 3);
    check("drain_pos_held", int'(position), 40);
    repeat (23) cycle(1'b1, 1'b0, 2'b01, 1'b0);
    check("drain_pos63", int'(position), 63);
    cycle(1'b1, 1'b0, 2'b01, 1'b0);
    check("drain_idle", int'(state), 0);
    check("drain_enable", int'(enable), 0);
    check("drain_pos0", int'(position), 0);

    // Async reset mid-walk at position 30
    cycle(1'b0, 1'b1, 2'b01, 1'b0);
    repeat (HOME_TICKS + 30) cycle(1'b1, 1'b1, 2'b01, 1'b0);
    check("pre_rst_pos", int'(position), 30);
    rst = 1'b1;
    #2;
    check("async_rst_state", int'(state), 0);
    check("async_rst_pos", int'(position), 0);
    check("async_rst_enable", int'(enable), 0);
    cycle(1'b1, 1'b1, 2'b01, 1'b1);
    cycle(1'b0, 1'b0, 2'b01, 1'b0);

    // start dropped mid-homing
    cycle(1'b0, 1'b1, 2'b01, 1'b0);
    repeat (100) cycle(1'b1, 1'b1, 2'b01, 1'b0);
    check("homing_mid", int'(state), 1);
    cycle(1'b1, 1'b0, 2'b01, 1'b0);
    check("homing_abort", int'(state), 0);

    // Randomized run
    rs = 1'b1;
    rc = 2'b01;
    repeat (12000) begin
      if (rs) begin
        if ($urandom_range(0, 999) == 0) rs = 1'b0;
      end else begin
        if ($urandom_range(0, 19) == 0) rs = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) rc = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 2999) == 0);
      rt = ($urandom_range(0, 2) != 0);
      cycle(rt, rs, rc, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
